// File: rtl/mgmt_mem_bist.sv
// ----------------------------------------------------------------------------
// mgmt_mem_bist
//   Built-in self-test engine for the management core SRAM (DEPTH x 32 bits,
//   byte-lane writable, 1-cycle synchronous read). After reset release it
//   waits STARTUP_DLY cycles and then runs three phases in order: word,
//   halfword and byte write/read-back. Progress and pass/fail codes are
//   published on la_output[31:16] for the logic-analyser monitor.
//
// Ports
//   core_clk      in   1   single clock, rising edge
//   core_rstn     in   1   asynchronous active-low reset
//   fault_inject  in   1   only with MEM_BIST_FAULT_INJECT_EN: while high,
//                          reads of word FAULT_ADDR return bit 0 inverted
//   la_output     out  38  [37:32] state code, [31:16] checkbits,
//                          [15:0] current element index (0 outside WRITE/READ)
//   gpio_out_pad  out  1   1 only in DONE_PASS
//
// Build option
//   MEM_BIST_FAULT_INJECT_EN - adds fault_inject and the read corruption path.
// ----------------------------------------------------------------------------
module mgmt_mem_bist #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned STARTUP_DLY = 16,
    parameter int unsigned FAULT_ADDR  = 5
) (
    input  logic        core_clk,
    input  logic        core_rstn,
`ifdef MEM_BIST_FAULT_INJECT_EN
    input  logic        fault_inject,
`endif
    output logic [37:0] la_output,
    output logic        gpio_out_pad
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DELAY     = 3'd1,
        S_ANNOUNCE  = 3'd2,
        S_WRITE     = 3'd3,
        S_READ      = 3'd4,
        S_RESULT    = 3'd5,
        S_DONE_PASS = 3'd6,
        S_DONE_FAIL = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        PH_WORD  = 2'd0,
        PH_SHORT = 2'd1,
        PH_BYTE  = 2'd2
    } phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] dly_q, dly_d;
    logic [15:0] cb_q, cb_d;
    logic        rd_cmp_q, rd_cmp_d;
    logic        fail_q, fail_d;
    logic        gpio_q, gpio_d;

    // RAM interface
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rdata_q;
    logic              mem_we;
    logic              mem_re;
    logic              rd_flip;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // Phase-dependent datapath
    logic [15:0] hval;
    logic [7:0]  bval;
    logic [15:0] last_idx;
    logic [31:0] rd_lane;
    logic [31:0] exp_data;
    logic        mismatch;

    function automatic logic [7:0] phase_pat(input phase_e p);
        logic [7:0] pat;
        pat = 8'h40;
        case (p)
            PH_SHORT: pat = 8'h20;
            PH_BYTE:  pat = 8'h10;
            default:  pat = 8'h40;
        endcase
        return pat;
    endfunction

    assign hval = idx_q ^ 16'h5A5A;
    assign bval = idx_q[7:0] ^ 8'hC3;

    // Element index -> word address, lane enables, write data, and the
    // zero-extended lane of the read word that the current element owns.
    always_comb begin
        last_idx  = 16'(DEPTH - 1);
        word_addr = idx_q[ADDR_W-1:0];
        wr_be     = 4'b1111;
        wr_data   = {~idx_q, idx_q};
        rd_lane   = rdata_q;
        exp_data  = {~idx_q, idx_q};
        case (phase_q)
            PH_SHORT: begin
                last_idx  = 16'(2 * DEPTH - 1);
                word_addr = idx_q[ADDR_W:1];
                wr_be     = idx_q[0] ? 4'b1100 : 4'b0011;
                wr_data   = {hval, hval};
                rd_lane   = {16'h0, (idx_q[0] ? rdata_q[31:16] : rdata_q[15:0])};
                exp_data  = {16'h0, hval};
            end
            PH_BYTE: begin
                last_idx  = 16'(4 * DEPTH - 1);
                word_addr = idx_q[ADDR_W+1:2];
                wr_be     = 4'b0001 << idx_q[1:0];
                wr_data   = {4{bval}};
                rd_lane   = {24'h0, rdata_q[{idx_q[1:0], 3'b000} +: 8]};
                exp_data  = {24'h0, bval};
            end
            default: ;
        endcase
    end

    assign mismatch = (rd_lane != exp_data);

`ifdef MEM_BIST_FAULT_INJECT_EN
    assign rd_flip = fault_inject && (word_addr == ADDR_W'(FAULT_ADDR));
`else
    assign rd_flip = 1'b0;
`endif

    // Single-port RAM, contents deliberately not reset.
    always_ff @(posedge core_clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end else if (mem_re) begin
            rdata_q <= mem[word_addr] ^ {31'h0, rd_flip};
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_WORD;
            idx_q    <= '0;
            dly_q    <= '0;
            cb_q     <= '0;
            rd_cmp_q <= 1'b0;
            fail_q   <= 1'b0;
            gpio_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            dly_q    <= dly_d;
            cb_q     <= cb_d;
            rd_cmp_q <= rd_cmp_d;
            fail_q   <= fail_d;
            gpio_q   <= gpio_d;
        end
    end

    // Checkbits and index are computed for the state being entered, so the
    // registered outputs line up with the registered state code.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        dly_d    = dly_q;
        cb_d     = cb_q;
        rd_cmp_d = rd_cmp_q;
        fail_d   = fail_q;
        gpio_d   = gpio_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_DELAY;
                dly_d   = '0;
            end
            S_DELAY: begin
                if (dly_q == 16'(STARTUP_DLY - 1)) begin
                    state_d = S_ANNOUNCE;
                    phase_d = PH_WORD;
                    cb_d    = {8'hA0, phase_pat(PH_WORD)};
                end else begin
                    dly_d = dly_q + 16'd1;
                end
            end
            S_ANNOUNCE: begin
                state_d = S_WRITE;
                cb_d    = '0;
                idx_d   = '0;
                fail_d  = 1'b0;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (idx_q == last_idx) begin
                    state_d  = S_READ;
                    idx_d    = '0;
                    rd_cmp_d = 1'b0;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            S_READ: begin
                if (!rd_cmp_q) begin
                    mem_re   = 1'b1;
                    rd_cmp_d = 1'b1;
                end else begin
                    rd_cmp_d = 1'b0;
                    if (mismatch) begin
                        state_d = S_RESULT;
                        fail_d  = 1'b1;
                        idx_d   = '0;
                        cb_d    = {8'hAB, phase_pat(phase_q)};
                    end else if (idx_q == last_idx) begin
                        state_d = S_RESULT;
                        idx_d   = '0;
                        cb_d    = {8'hAB, phase_pat(phase_q) | 8'h01};
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            S_RESULT: begin
                if (fail_q) begin
                    state_d = S_DONE_FAIL;
                end else if (phase_q == PH_BYTE) begin
                    state_d = S_DONE_PASS;
                    gpio_d  = 1'b1;
                end else begin
                    state_d = S_ANNOUNCE;
                    phase_d = (phase_q == PH_WORD) ? PH_SHORT : PH_BYTE;
                    cb_d    = {8'hA0, ((phase_q == PH_WORD) ? phase_pat(PH_SHORT)
                                                            : phase_pat(PH_BYTE))};
                end
            end
            default: ;
        endcase
    end

    assign la_output    = {3'b000, state_q, cb_q, idx_q};
    assign gpio_out_pad = gpio_q;

endmodule

// File: tb/tb_mgmt_mem_bist.sv
`timescale 1ns/1ps
module tb_mgmt_mem_bist;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int SDLY   = 16;
    localparam int FADDR  = 5;

    logic        core_clk  = 1'b0;
    logic        core_rstn = 1'b0;
    logic [37:0] la_output;
    logic        gpio_out_pad;
`ifdef MEM_BIST_FAULT_INJECT_EN
    logic        fault_inject = 1'b0;
`endif

    mgmt_mem_bist #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .STARTUP_DLY(SDLY),
        .FAULT_ADDR(FADDR)
    ) dut (
        .core_clk(core_clk),
        .core_rstn(core_rstn),
`ifdef MEM_BIST_FAULT_INJECT_EN
        .fault_inject(fault_inject),
`endif
        .la_output(la_output),
        .gpio_out_pad(gpio_out_pad)
    );

    always #5 core_clk = ~core_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_edges = 0;
    bit          mon_en = 1'b0;
    int          mdl_fph = 3;   // phase that fails (3 = none)
    int          mdl_fel = 0;   // failing element index in that phase
    logic [15:0] seen[$];
    logic [15:0] prev_cb = '0;
    logic [15:0] last_rd_ix = '0;

    typedef struct {
        int          n;
        logic [5:0]  st;
        logic [15:0] cb;
        logic [15:0] ix;
        logic        gp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected outputs n rising edges after reset release, from the phase
    // timeline: ANNOUNCE 1, WRITE N, READ 2 per element, RESULT 1.
    function automatic logic [38:0] model(input int n, input int fph, input int fel);
        int         t, nel, rdl;
        logic [7:0] pat;
        if (n == 0) return 39'd0;
        if (n <= SDLY) return {6'd1, 32'h0, 1'b0};
        t = n - SDLY - 1;
        for (int p = 0; p < 3; p++) begin
            nel = DEPTH << p;
            pat = 8'h40 >> p;
            rdl = (fph == p) ? 2 * fel + 2 : 2 * nel;
            if (t == 0) return {6'd2, 8'hA0, pat, 16'h0, 1'b0};
            t -= 1;
            if (t < nel) return {6'd3, 16'h0, 16'(t), 1'b0};
            t -= nel;
            if (t < rdl) return {6'd4, 16'h0, 16'(t / 2), 1'b0};
            t -= rdl;
            if (t == 0) return {6'd5, 8'hAB, ((fph == p) ? pat : (pat | 8'h01)), 16'h0, 1'b0};
            t -= 1;
            if (fph == p) return {6'd7, 8'hAB, pat, 16'h0, 1'b0};
        end
        return {6'd6, 16'hAB11, 16'h0, 1'b1};
    endfunction

    always @(posedge core_clk) begin
        if (!core_rstn) n_edges <= 0;
        else            n_edges <= n_edges + 1;
    end

    // Cycle-by-cycle trace check against the model.
    always @(negedge core_clk) begin
        logic [38:0] e;
        logic [15:0] cb;
        logic        legal;
        if (mon_en) begin
            if (!core_rstn) begin
                check("reset-out", {25'b0, la_output, gpio_out_pad}, 64'h0);
                seen.delete();
                prev_cb    = '0;
                last_rd_ix = '0;
            end else begin
                e = model(n_edges, mdl_fph, mdl_fel);
                check("trace", {25'b0, la_output, gpio_out_pad}, {25'b0, e});
                cb    = la_output[31:16];
                legal = cb inside {16'h0000, 16'hA040, 16'hA020, 16'hA010, 16'hAB41,
                                   16'hAB21, 16'hAB11, 16'hAB40, 16'hAB20, 16'hAB10};
                check("legal-code", {63'b0, legal}, 64'd1);
                if (cb != prev_cb && cb != 16'h0) seen.push_back(cb);
                prev_cb = cb;
                if (la_output[37:32] == 6'd4) last_rd_ix = la_output[15:0];
                if (n_err > 30) mon_en = 1'b0;
            end
        end
    end

    task automatic add_vec(input int n, input logic [5:0] st, input logic [15:0] cb,
                           input logic [15:0] ix, input logic gp);
        vec_t v;
        v.n = n; v.st = st; v.cb = cb; v.ix = ix; v.gp = gp;
        vecs.push_back(v);
    endtask

    task automatic pulse_reset(input int hold);
        @(posedge core_clk);
        #1 core_rstn = 1'b0;
        repeat (hold) @(posedge core_clk);
        #1 core_rstn = 1'b1;
    endtask

    task automatic wait_state(input logic [5:0] code, input int budget);
        int k;
        k = 0;
        @(negedge core_clk);
        while (la_output[37:32] !== code && k < budget) begin
            @(negedge core_clk);
            k++;
        end
        check("wait-state", {58'b0, la_output[37:32]}, {58'b0, code});
    endtask

    task automatic check_seq(input logic [95:0] codes, input int cnt);
        check("seq-len", 64'(seen.size()), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (i < seen.size())
                check("seq-code", {48'b0, seen[i]}, {48'b0, codes[95 - 16*i -: 16]});
        end
    endtask

    localparam logic [95:0] PASS_SEQ =
        {16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB11};

    initial begin
        int target;
        // Hand-derived timeline points for a clean run (n = edges after release).
        add_vec(0,     6'd0, 16'h0000, 16'd0,    1'b0);
        add_vec(1,     6'd1, 16'h0000, 16'd0,    1'b0);
        add_vec(16,    6'd1, 16'h0000, 16'd0,    1'b0);
        add_vec(17,    6'd2, 16'hA040, 16'd0,    1'b0);
        add_vec(18,    6'd3, 16'h0000, 16'd0,    1'b0);
        add_vec(529,   6'd3, 16'h0000, 16'd511,  1'b0);
        add_vec(530,   6'd4, 16'h0000, 16'd0,    1'b0);
        add_vec(531,   6'd4, 16'h0000, 16'd0,    1'b0);
        add_vec(532,   6'd4, 16'h0000, 16'd1,    1'b0);
        add_vec(1553,  6'd4, 16'h0000, 16'd511,  1'b0);
        add_vec(1554,  6'd5, 16'hAB41, 16'd0,    1'b0);
        add_vec(1555,  6'd2, 16'hA020, 16'd0,    1'b0);
        add_vec(1556,  6'd3, 16'h0000, 16'd0,    1'b0);
        add_vec(2579,  6'd3, 16'h0000, 16'd1023, 1'b0);
        add_vec(2580,  6'd4, 16'h0000, 16'd0,    1'b0);
        add_vec(4627,  6'd4, 16'h0000, 16'd1023, 1'b0);
        add_vec(4628,  6'd5, 16'hAB21, 16'd0,    1'b0);
        add_vec(4629,  6'd2, 16'hA010, 16'd0,    1'b0);
        add_vec(6677,  6'd3, 16'h0000, 16'd2047, 1'b0);
        add_vec(6678,  6'd4, 16'h0000, 16'd0,    1'b0);
        add_vec(10773, 6'd4, 16'h0000, 16'd2047, 1'b0);
        add_vec(10774, 6'd5, 16'hAB11, 16'd0,    1'b0);
        add_vec(10775, 6'd6, 16'hAB11, 16'd0,    1'b1);
        add_vec(10800, 6'd6, 16'hAB11, 16'd0,    1'b1);

        mon_en = 1'b1;
        // Reset held for 50 cycles: monitor expects all-zero outputs.
        repeat (50) @(posedge core_clk);
        #1 core_rstn = 1'b1;
        @(negedge core_clk);
        foreach (vecs[i]) begin
            while (n_edges < vecs[i].n) @(negedge core_clk);
            check("vec", {25'b0, la_output, gpio_out_pad},
                  {25'b0, vecs[i].st, vecs[i].cb, vecs[i].ix, vecs[i].gp});
        end
        check_seq(PASS_SEQ, 6);

        // Reset during the halfword WRITE, then a full rerun.
        pulse_reset(2);
        target = 1556 + int'($urandom_range(0, 1000));
        @(negedge core_clk);
        while (n_edges < target) @(negedge core_clk);
        check("pre-reset", {42'b0, la_output[37:32], la_output[15:0]},
              {42'b0, 6'd3, 16'(target - 1556)});
        @(posedge core_clk);
        #1 core_rstn = 1'b0;
        #1 check("reset-clear", {25'b0, la_output, gpio_out_pad}, 64'h0);
        repeat (int'($urandom_range(1, 8))) @(posedge core_clk);
        #1 core_rstn = 1'b1;
        wait_state(6'd6, 12000);
        check_seq(PASS_SEQ, 6);

        // Random abort points, then a final uninterrupted run.
        for (int k = 0; k < 2; k++) begin
            pulse_reset(int'($urandom_range(1, 8)));
            target = int'($urandom_range(1, 6000));
            @(negedge core_clk);
            while (n_edges < target) @(negedge core_clk);
            pulse_reset(int'($urandom_range(1, 8)));
        end
        wait_state(6'd6, 12000);
        check_seq(PASS_SEQ, 6);
        repeat (10) @(negedge core_clk);
        check("pass-hold", {25'b0, la_output, gpio_out_pad},
              {25'b0, 6'd6, 16'hAB11, 16'h0, 1'b1});

`ifdef MEM_BIST_FAULT_INJECT_EN
        // Fault active from reset: word phase fails at element FADDR.
        @(posedge core_clk);
        #1 core_rstn = 1'b0;
        mdl_fph = 0;
        mdl_fel = FADDR;
        fault_inject = 1'b1;
        repeat (3) @(posedge core_clk);
        #1 core_rstn = 1'b1;
        wait_state(6'd7, 3000);
        check("fail-word-code", {48'b0, la_output[31:16]}, {48'b0, 16'hAB40});
        check("fail-word-ix", {48'b0, last_rd_ix}, 64'(FADDR));
        repeat (20) @(negedge core_clk);
        check("fail-word-hold", {25'b0, la_output, gpio_out_pad},
              {25'b0, 6'd7, 16'hAB40, 16'h0, 1'b0});
        check_seq({16'hA040, 16'hAB40, 64'h0}, 2);

        // Fault raised after the word phase passes: halfword fails at 2*FADDR.
        @(posedge core_clk);
        #1 core_rstn = 1'b0;
        mdl_fph = 1;
        mdl_fel = 2 * FADDR;
        fault_inject = 1'b0;
        repeat (3) @(posedge core_clk);
        #1 core_rstn = 1'b1;
        begin
            int k;
            k = 0;
            @(negedge core_clk);
            while (la_output[31:16] !== 16'hAB41 && k < 3000) begin
                @(negedge core_clk);
                k++;
            end
            check("see-AB41", {48'b0, la_output[31:16]}, {48'b0, 16'hAB41});
        end
        #1 fault_inject = 1'b1;
        wait_state(6'd7, 6000);
        check("fail-short-code", {48'b0, la_output[31:16]}, {48'b0, 16'hAB20});
        check("fail-short-ix", {48'b0, last_rd_ix}, 64'(2 * FADDR));
        repeat (20) @(negedge core_clk);
        check("fail-short-hold", {25'b0, la_output, gpio_out_pad},
              {25'b0, 6'd7, 16'hAB20, 16'h0, 1'b0});
        check_seq({16'hA040, 16'hAB41, 16'hA020, 16'hAB20, 32'h0}, 4);
        fault_inject = 1'b0;
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
